// File: rtl/arbiter_rr_buffered.sv
// rtl/arbiter_rr_buffered.sv - round-robin N:1 arbiter feeding a one-entry registered output stage
// The grant is combinational from the pointer; the output word, id and pointer are registered.
module arbiter_rr_buffered #(
  parameter int DWIDTH = 8,
  parameter int N      = 2,
  localparam int IDW   = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid [N-1:0],
  input  logic [DWIDTH-1:0] in_data  [N-1:0],
  output logic              in_ready [N-1:0],
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready
);

  logic              full;
  logic [DWIDTH-1:0] data;
  logic [IDW-1:0]    id;
  logic [IDW-1:0]    ptr;

  logic              grant_valid;
  logic [IDW-1:0]    grant_idx;
  logic              can_load;
  logic              xfer;

  // Search ptr, ptr+1, ... with wrap; the first valid requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!grant_valid && in_valid[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IDW'(j);
      end
    end
  end

  assign can_load = ~full | out_ready;
  assign xfer     = grant_valid & can_load & ~rst;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer && (grant_idx == IDW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
      id   <= '0;
      ptr  <= '0;
    end else if (xfer) begin
      full <= 1'b1;
      data <= in_data[grant_idx];
      id   <= grant_idx;
      ptr  <= (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end else if (out_ready) begin
      full <= 1'b0;
    end
  end

  assign out_valid = full;
  assign out_data  = data;
  assign out_id    = id;

endmodule

// File: tb/tb_arbiter_rr_buffered.sv
// tb/tb_arbiter_rr_buffered.sv - directed and random checks of arbiter_rr_buffered against a queue-free reference model
module tb_arbiter_rr_buffered;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid [N-1:0];
  logic [DW-1:0] in_data  [N-1:0];
  logic          in_ready [N-1:0];
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_id;
  logic          out_ready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: what the output register and priority should be.
  int m_full, m_data, m_id, m_ptr;

  arbiter_rr_buffered #(.DWIDTH(DW), .N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (in_valid[idx] === 1'b1) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_full = 0; m_data = 0; m_id = 0; m_ptr = 0;
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic step();
    int g;
    bit ld;
    #3;
    g  = model_grant();
    ld = (rst === 1'b0) && (m_full == 0 || out_ready === 1'b1);
    for (int i = 0; i < N; i++)
      chk($sformatf("in_ready[%0d]", i), in_ready[i], (ld && g == i) ? 1 : 0);
    @(posedge clk);
    #1;
    if (rst === 1'b1) model_reset();
    else if (ld && g >= 0) begin
      m_full = 1; m_data = in_data[g]; m_id = g; m_ptr = (g + 1) % N;
    end else if (out_ready === 1'b1) m_full = 0;
    chk("out_valid", out_valid, m_full);
    chk("out_data", out_data, m_data);
    chk("out_id", out_id, m_id);
  endtask

  task automatic set_valid(input logic [3:0] v);
    for (int i = 0; i < N; i++) begin
      in_valid[i] = v[i];
      in_data[i]  = DW'($urandom);
    end
  endtask

  initial begin
    logic [DW-1:0] d0;
    int seq [6] = '{0, 1, 2, 3, 0, 1};

    model_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    set_valid(4'hF);
    #2;
    for (int i = 0; i < N; i++) chk("reset in_ready", in_ready[i], 0);
    chk("reset out_valid", out_valid, 0);
    @(posedge clk); #1;
    step();

    // Release reset: req0 must win the very first edge.
    rst = 1'b0;
    out_ready = 1'b1;
    set_valid(4'hF);
    d0 = in_data[0];
    step();
    chk("first out_id", out_id, 0);
    chk("first out_data", out_data, d0);

    // Fairness: continuous requests give 1,2,3,0,1 after the first word.
    for (int k = 1; k < 6; k++) begin
      set_valid(4'hF);
      step();
      chk($sformatf("fair id %0d", k), out_id, seq[k]);
      chk($sformatf("fair valid %0d", k), out_valid, 1);
    end

    // Backpressure with 0xA5 held.
    set_valid(4'b0001);
    in_data[0] = 8'hA5;
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_valid(4'hF);
      step();
      chk("hold data", out_data, 8'hA5);
      chk("hold id", out_id, 0);
    end
    out_ready = 1'b1;
    set_valid(4'hF);
    step();
    chk("release valid", out_valid, 1);
    chk("release id", out_id, 1);

    // Drain after a single req2 transfer; ptr must stay at 3 while idle.
    set_valid(4'b0000);
    step();
    set_valid(4'b0100);
    step();
    chk("drain id", out_id, 2);
    set_valid(4'b0000);
    step();
    chk("drain valid", out_valid, 0);
    step();
    step();

    // Wrap and skip: req3 first, then req1.
    set_valid(4'b1010);
    step();
    chk("wrap id3", out_id, 3);
    set_valid(4'b1010);
    step();
    chk("wrap id1", out_id, 1);

    // Mid-operation reset while full and stalled.
    out_ready = 1'b0;
    set_valid(4'hF);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("async out_valid", out_valid, 0);
    chk("async out_data", out_data, 0);
    for (int i = 0; i < N; i++) chk("async in_ready", in_ready[i], 0);
    model_reset();
    #0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    set_valid(4'hF);
    d0 = in_data[0];
    step();
    chk("post-reset id", out_id, 0);
    chk("post-reset data", out_data, d0);

    // Random phase; idle requesters carry X data.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        in_valid[i] = ($urandom_range(0, 1) == 1);
        in_data[i]  = in_valid[i] ? DW'($urandom) : 'x;
      end
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/arbiter_rr_buffered.md
ARBITER_RR_BUFFERED -- requirements
Module: arbiter_rr_buffered

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, meaning the payload width in bits.
REQ-002 SHALL have parameter N, default 2, meaning the number of requesters; legal range 2..16.
REQ-003 SHALL derive the local constant IDW = $clog2(N), the width of the source index.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, the reset; asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit x N (unpacked [N-1:0]), the per-requester valid.
REQ-007 SHALL have port in_data, input, DWIDTH x N (unpacked [N-1:0]), the per-requester payload.
REQ-008 SHALL have port in_ready, output, 1 bit x N (unpacked [N-1:0]), the per-requester accept.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning the output register holds a word.
REQ-010 SHALL have port out_data, output, DWIDTH, the registered payload.
REQ-011 SHALL have port out_id, output, IDW, the index of the requester that supplied out_data.
REQ-012 SHALL have port out_ready, input, 1 bit, the downstream accept.

Function
REQ-013 SHALL hold a one-entry output register (full flag, data, id) with out_valid = full.
REQ-014 SHALL hold a round-robin pointer ptr (IDW bits), where ptr is the highest-priority index.
REQ-015 SHALL compute the grant combinationally: the first i with in_valid[i]=1, searching ptr, ptr+1, ... N-1, 0, ... ptr-1 (wrap-around); at most one grant is active.
REQ-016 SHALL compute can_load = ~full | out_ready.
REQ-017 SHALL drive in_ready[i] = grant[i] & can_load & ~rst; all other in_ready SHALL be 0.
REQ-018 SHALL define a transfer as in_valid[g] & in_ready[g] for the granted index g; at most one transfer per cycle.
REQ-019 On a transfer, SHALL load data <= in_data[g], id <= g, full <= 1 at the next edge; latency is exactly 1 cycle from transfer to out_valid.
REQ-020 On a transfer, SHALL update ptr <= (g+1) mod N; if g = N-1, ptr SHALL become 0.
REQ-021 With no transfer, ptr SHALL hold its value; idle cycles SHALL NOT advance priority.
REQ-022 On out_valid & out_ready with no transfer, SHALL clear full; data and id SHALL hold their stale values.
REQ-023 On out_valid & out_ready in the same cycle as a transfer, SHALL load the new word with full remaining 1; back-to-back throughput is 1 word per cycle.
REQ-024 While full & ~out_ready, SHALL hold out_valid, out_data and out_id stable, and all in_ready SHALL be 0.
REQ-025 SHALL NOT depend on in_data of non-granted requesters; X on those SHALL NOT propagate.
REQ-026 A requester that drops in_valid before a transfer SHALL lose the grant; no state is retained for it.
REQ-027 The only combinational input-to-output paths SHALL be in_valid -> in_ready and out_ready -> in_ready; out_* SHALL be registered.

Reset
REQ-028 While rst=1, SHALL force full=0, out_valid=0, out_data=0, out_id=0, ptr=0, and all in_ready=0, independent of clk.
REQ-029 A reset asserted mid-operation SHALL discard the held word; after deassertion the first grant SHALL start at index 0.
REQ-030 SHALL permit a transfer on the first rising edge after rst falls.

Verification (N=4, DWIDTH=8)
REQ-031 Reset: hold rst=1 with all in_valid=1 -> all in_ready=0 and out_valid=0; release with out_ready=1 -> req0 wins the first cycle and out_data=in_data[0], out_id=0 one cycle later.
REQ-032 Fairness: all four requesters valid continuously with out_ready=1 -> out_id sequence 0,1,2,3,0,1, one word per cycle with no bubbles.
REQ-033 Backpressure: out_ready=0 with out_valid=1 and data 0xA5 -> out_data stays 0xA5, out_id stable and all in_ready=0 for 5 cycles; raise out_ready -> the next word loads on the same edge.
REQ-034 Wrap and skip: ptr=3 with only req1 and req3 valid -> req3 is granted, then ptr=0 and req1 is granted next.
REQ-035 Drain: a single transfer from req2, then out_ready=1 with no requests -> out_valid falls after one cycle and ptr=3 holds.
REQ-036 Mid-reset: assert rst while full with out_ready=0 -> out_valid falls asynchronously and the held word is never delivered.
